pcie_rd_tag_tracker: RTL and testbench
======================================

// Module: pcie_rd_tag_tracker
// PURPOSE
//  Requester-side tag allocator and completion tracker for upstream MRd TLPs on the TX AVST path.
//  Hands out unique tags and reserves completion credit (DW) per read request.
//  Retires tags when the final completion arrives on RX.
//  Flags unexpected completions and completion timeouts into the t_tlp_err fields err_unexp_cpl / err_cpl_timeout.
// PARAMETERS
//  NUM_TAGS        256                tags in pool (ofs_fim_pcie_pkg::PCIE_EP_MAX_TAGS); any value 2..256
//  TIMEOUT_CYCLES  PCIE_CPL_TIMEOUT   clk cycles from allocation to timeout (sim builds: 256)
//  CREDIT_DW       CPL_CREDIT_DWORD   total completion buffer, DW (10000)
// PORTS
//  clk              in   1                   clock
//  rst_n            in   1                   async active-low reset
//  alloc_req        in   1                   TX wants a tag for an MRd
//  alloc_len_dw     in   PCIE_MAX_LEN_WIDTH  MRd length, DW, 1..1024
//  alloc_ready      out  1                   tag + credit available; alloc when req&&ready
//  alloc_tag        out  PCIE_EP_TAG_WIDTH   tag granted (valid while alloc_ready)
//  cpl_valid        in   1                   RX completion header seen (sop)
//  cpl_tag          in   PCIE_EP_TAG_WIDTH   completion tag
//  cpl_len_dw       in   PCIE_MAX_LEN_WIDTH  payload DW in this completion
//  cpl_last         in   1                   final completion of request (byte count done)
//  credit_avail     out  CPL_CREDIT_WIDTH+1  unreserved completion DW
//  outstanding_cnt  out  PCIE_EP_TAG_WIDTH+1 tags in flight
//  err_unexp_cpl    out  1                   1-cycle pulse
//  err_cpl_timeout  out  1                   1-cycle pulse
//  timeout_tag      out  PCIE_EP_TAG_WIDTH   tag that timed out (held until next timeout)
//  stat_timeout_cnt out  16                  saturating timeout count (stats build only)
//  stat_unexp_cnt   out  16                  saturating unexpected-cpl count (stats build only)
// BEHAVIOUR
//  Reset: all outputs 0; credit_avail := CREDIT_DW after reset; FSM=INIT.
//  FSM INIT: pushes tags 0..NUM_TAGS-1 into free FIFO, one per cycle; alloc_ready=0; cpls flagged unexpected.
//  FSM INIT -> RUN after NUM_TAGS cycles; RUN is terminal until reset.
//  alloc_ready = RUN && FIFO non-empty && credit_avail >= alloc_len_dw (combinational on len).
//  On alloc: pop FIFO; entry{outstanding=1, ts=now, rem=len}; credit -= len; effective next cycle.
//  now: free-running CPL_TIME_WIDTH counter; age = now-ts modulo 2^CPL_TIME_WIDTH (wrap-safe).
//  cpl on tag not outstanding: err_unexp_cpl next cycle; no state change.
//  cpl on tag outstanding: ret=min(cpl_len,rem); rem-=ret; credit+=ret.
//  cpl with cpl_last: additionally return residual rem; clear outstanding; push tag to FIFO.
//  Timeout scanner: one tag index per cycle, round-robin 0..NUM_TAGS-1, wrap to 0 (incr_tlp_tag).
//  On age >= TIMEOUT_CYCLES: retire the tag as for cpl_last; pulse err_cpl_timeout; latch timeout_tag.
//  Detection latency <= TIMEOUT_CYCLES+NUM_TAGS.
//  Scanner holds its index (no check) in any cycle a cpl retires a tag: one FIFO push per cycle.
//  Same-tag cpl and timeout in same cycle: completion wins, no timeout.
//  Freed tag not re-allocatable in same cycle; alloc+cpl same cycle: credit net = +ret-len.
//  Credit never exceeds CREDIT_DW (assertion).
//  Reset mid-operation: all entries cleared, FSM back to INIT, in-flight tags forgotten.
// CONFIGURATION
//  PCIE_TAG_TRACKER_STATS_EN defined: stat_* count err pulses, saturate at 16'hFFFF, reset to 0.
//  PCIE_TAG_TRACKER_STATS_EN undefined: stat_* tied 0; counter logic absent.
// STRUCTURE
//  ofs_fim_pcie_pkg supplies t_tlp_tag, PCIE_EP_MAX_TAGS, PCIE_CPL_TIMEOUT, CPL_TIME_WIDTH,
//  CPL_CREDIT_WIDTH, PCIE_MAX_LEN_WIDTH, incr_tlp_tag.
//  Add to ofs_fim_pcie_pkg: t_tag_entry {outstanding, ts[CPL_TIME_WIDTH], rem[PCIE_MAX_LEN_WIDTH]}.
//  Sub-module pcie_tag_free_fifo: NUM_TAGS-deep sync FIFO, 1 push + 1 pop per cycle.
// TESTING
//  After reset -> alloc_ready=0 for 256 cycles, then alloc_tag=0, credit_avail=10000.
//  Alloc len 16 on tag 5; cpl 8 DW; cpl 8 DW last -> credit back to 10000, outstanding_cnt=0.
//  cpl_valid tag 7 never allocated -> err_unexp_cpl pulse; credit/outstanding unchanged.
//  TIMEOUT=256; alloc tag 3 len 32, no cpl -> err_cpl_timeout within 512 cycles, timeout_tag=3, credit +32.
//  Alloc 256 tags len 1 -> alloc_ready=0; one cpl_last tag 9 -> ready next cycle, alloc_tag=9.
//  alloc_len 1024 with credit 1000 -> alloc_ready=0; STATS_EN build: 3 unexp cpls -> stat_unexp_cnt=3.

Source files
------------

// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe FIM types and sizing used by the read-tag tracker.
// Holds tag/credit/length widths, the per-tag tracking entry and the tag increment helper.
package ofs_fim_pcie_pkg;

   localparam int PCIE_EP_MAX_TAGS   = 256;
   localparam int PCIE_EP_TAG_WIDTH  = 8;
   localparam int PCIE_CPL_TIMEOUT   = 256;
   localparam int CPL_TIME_WIDTH     = 16;
   localparam int CPL_CREDIT_DWORD   = 10000;
   localparam int CPL_CREDIT_WIDTH   = 14;
   localparam int PCIE_MAX_LEN_WIDTH = 11;

   typedef logic [PCIE_EP_TAG_WIDTH-1:0] t_tlp_tag;

   typedef struct packed {
      logic                          outstanding;
      logic [CPL_TIME_WIDTH-1:0]     ts;
      logic [PCIE_MAX_LEN_WIDTH-1:0] rem;
   } t_tag_entry;

   typedef enum logic {
      TRK_INIT,
      TRK_RUN
   } t_trk_state;

   function automatic t_tlp_tag incr_tlp_tag(input t_tlp_tag tag);
      return tag + t_tlp_tag'(1);
   endfunction

endpackage

// File: rtl/pcie_rd_tag_tracker_if.sv
// Allocation (TX MRd) and completion (RX) handshake bundle for the read-tag tracker.
// master = TX/RX request side, slave = tracker.
interface pcie_rd_tag_tracker_if;
   import ofs_fim_pcie_pkg::*;

   logic                          alloc_req;
   logic [PCIE_MAX_LEN_WIDTH-1:0] alloc_len_dw;
   logic                          alloc_ready;
   t_tlp_tag                      alloc_tag;
   logic                          cpl_valid;
   t_tlp_tag                      cpl_tag;
   logic [PCIE_MAX_LEN_WIDTH-1:0] cpl_len_dw;
   logic                          cpl_last;

   modport master (
      output alloc_req, alloc_len_dw, cpl_valid, cpl_tag, cpl_len_dw, cpl_last,
      input  alloc_ready, alloc_tag
   );

   modport slave (
      input  alloc_req, alloc_len_dw, cpl_valid, cpl_tag, cpl_len_dw, cpl_last,
      output alloc_ready, alloc_tag
   );

endinterface

// File: rtl/pcie_tag_free_fifo.sv
// Free-tag pool: NUM_TAGS-deep synchronous FIFO, one push and one pop per cycle.
// The head entry is presented combinationally so a grant needs no extra read cycle.
module pcie_tag_free_fifo
   import ofs_fim_pcie_pkg::*;
#(
   parameter int NUM_TAGS = PCIE_EP_MAX_TAGS
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  t_tlp_tag push_tag,
   input  logic     pop,
   output t_tlp_tag head_tag,
   output logic     empty
);

   localparam int AW = $clog2(NUM_TAGS);
   localparam logic [AW-1:0] LAST_PTR = AW'(NUM_TAGS - 1);

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
   endfunction

   t_tlp_tag      mem [NUM_TAGS];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   assign head_tag = mem[rd_ptr];
   assign empty    = (count == '0);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= next_ptr(wr_ptr);
         if (pop)
            rd_ptr <= next_ptr(rd_ptr);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

endmodule

// File: rtl/pcie_rd_tag_tracker.sv
// Requester-side MRd tag allocator / completion tracker with credit reservation and timeout scan.
// Optional build macro PCIE_TAG_TRACKER_STATS_EN enables saturating error statistics counters.
module pcie_rd_tag_tracker
   import ofs_fim_pcie_pkg::*;
#(
   parameter int NUM_TAGS       = PCIE_EP_MAX_TAGS,
   parameter int TIMEOUT_CYCLES = PCIE_CPL_TIMEOUT,
   parameter int CREDIT_DW      = CPL_CREDIT_DWORD
) (
   input  logic                        clk,
   input  logic                        rst_n,
   pcie_rd_tag_tracker_if.slave        trk,
   output logic [CPL_CREDIT_WIDTH:0]   credit_avail,
   output logic [PCIE_EP_TAG_WIDTH:0]  outstanding_cnt,
   output logic                        err_unexp_cpl,
   output logic                        err_cpl_timeout,
   output t_tlp_tag                    timeout_tag,
   output logic [15:0]                 stat_timeout_cnt,
   output logic [15:0]                 stat_unexp_cnt
);

   localparam int CW = CPL_CREDIT_WIDTH + 1;
   localparam int OW = PCIE_EP_TAG_WIDTH + 1;
   localparam int LW = PCIE_MAX_LEN_WIDTH;
   localparam logic [CW-1:0]             CREDIT_MAX = CW'(CREDIT_DW);
   localparam logic [CPL_TIME_WIDTH-1:0] TIMEOUT_T  = CPL_TIME_WIDTH'(TIMEOUT_CYCLES);
   localparam t_tlp_tag                  LAST_TAG   = t_tlp_tag'(NUM_TAGS - 1);

   function automatic logic [LW-1:0] min_len(input logic [LW-1:0] a, input logic [LW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   t_trk_state                state, state_nxt;
   t_tlp_tag                  init_tag, scan_idx, fifo_head, fifo_push_tag;
   logic [CPL_TIME_WIDTH-1:0] now, scan_age;
   t_tag_entry                entries [NUM_TAGS];
   logic                      fifo_push, fifo_pop, fifo_empty;
   logic                      alloc_fire, cpl_tag_ok, cpl_hit, cpl_unexp, cpl_retire;
   logic                      scan_en, to_hit;
   logic [LW-1:0]             cpl_rem, cpl_ret, to_ret;
   logic [CW-1:0]             credit_nxt;
   logic [OW-1:0]             out_nxt;

   // Control FSM: INIT seeds the free pool, RUN recycles retired tags into it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= TRK_INIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      fifo_push     = 1'b0;
      fifo_push_tag = '0;
      case (state)
         TRK_INIT: begin
            fifo_push     = 1'b1;
            fifo_push_tag = init_tag;
            if (init_tag == LAST_TAG)
               state_nxt = TRK_RUN;
         end
         TRK_RUN: begin
            if (cpl_retire) begin
               fifo_push     = 1'b1;
               fifo_push_tag = trk.cpl_tag;
            end else if (to_hit) begin
               fifo_push     = 1'b1;
               fifo_push_tag = scan_idx;
            end
         end
         default: state_nxt = TRK_INIT;
      endcase
   end

   pcie_tag_free_fifo #(.NUM_TAGS(NUM_TAGS)) u_free_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_tag (fifo_push_tag),
      .pop      (fifo_pop),
      .head_tag (fifo_head),
      .empty    (fifo_empty)
   );

   // Completion lookup; a final completion returns whatever reservation is left
   assign cpl_tag_ok = ({1'b0, trk.cpl_tag} < OW'(NUM_TAGS));
   assign cpl_hit    = trk.cpl_valid && cpl_tag_ok && entries[trk.cpl_tag].outstanding;
   assign cpl_unexp  = trk.cpl_valid && !cpl_hit;
   assign cpl_retire = cpl_hit && trk.cpl_last;
   assign cpl_rem    = entries[trk.cpl_tag].rem;
   assign cpl_ret    = trk.cpl_last ? cpl_rem : min_len(trk.cpl_len_dw, cpl_rem);

   // Scanner pauses when a completion already owns the free-pool push this cycle
   assign scan_en  = (state == TRK_RUN) && !cpl_retire;
   assign scan_age = now - entries[scan_idx].ts;
   assign to_ret   = entries[scan_idx].rem;
   assign to_hit   = scan_en && entries[scan_idx].outstanding && (scan_age >= TIMEOUT_T) &&
                     !(cpl_hit && (trk.cpl_tag == scan_idx));

   assign trk.alloc_ready = (state == TRK_RUN) && !fifo_empty &&
                            (credit_avail >= CW'(trk.alloc_len_dw));
   assign trk.alloc_tag   = fifo_head;
   assign alloc_fire      = trk.alloc_req && trk.alloc_ready;
   assign fifo_pop        = alloc_fire;

   assign credit_nxt = credit_avail
                     + (cpl_hit    ? CW'(cpl_ret)          : '0)
                     + (to_hit     ? CW'(to_ret)           : '0)
                     - (alloc_fire ? CW'(trk.alloc_len_dw) : '0);
   assign out_nxt    = outstanding_cnt + OW'(alloc_fire) - OW'(cpl_retire) - OW'(to_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_tag        <= '0;
         scan_idx        <= '0;
         now             <= '0;
         credit_avail    <= CREDIT_MAX;
         outstanding_cnt <= '0;
         err_unexp_cpl   <= 1'b0;
         err_cpl_timeout <= 1'b0;
         timeout_tag     <= '0;
      end else begin
         now <= now + CPL_TIME_WIDTH'(1);
         if (state == TRK_INIT)
            init_tag <= incr_tlp_tag(init_tag);
         if (scan_en)
            scan_idx <= (scan_idx == LAST_TAG) ? '0 : incr_tlp_tag(scan_idx);
         credit_avail    <= credit_nxt;
         outstanding_cnt <= out_nxt;
         err_unexp_cpl   <= cpl_unexp;
         err_cpl_timeout <= to_hit;
         if (to_hit)
            timeout_tag <= scan_idx;
      end
   end

   // Tag table: alloc, completion and timeout always address distinct tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_TAGS; i++)
            entries[i] <= '0;
      end else begin
         if (alloc_fire)
            entries[trk.alloc_tag] <= '{outstanding: 1'b1, ts: now, rem: trk.alloc_len_dw};
         if (cpl_hit) begin
            entries[trk.cpl_tag].rem <= trk.cpl_last ? '0 : cpl_rem - cpl_ret;
            if (trk.cpl_last)
               entries[trk.cpl_tag].outstanding <= 1'b0;
         end
         if (to_hit)
            entries[scan_idx].outstanding <= 1'b0;
      end
   end

   credit_cap_a: assert property (@(posedge clk) disable iff (!rst_n) credit_avail <= CREDIT_MAX);

`ifdef PCIE_TAG_TRACKER_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_timeout_cnt <= '0;
         stat_unexp_cnt   <= '0;
      end else begin
         if (err_cpl_timeout)
            stat_timeout_cnt <= sat_inc(stat_timeout_cnt);
         if (err_unexp_cpl)
            stat_unexp_cnt <= sat_inc(stat_unexp_cnt);
      end
   end
`else
   assign stat_timeout_cnt = '0;
   assign stat_unexp_cnt   = '0;
`endif

endmodule

// File: tb/tb_pcie_rd_tag_tracker.sv
// Self-checking bench for pcie_rd_tag_tracker; error pulses are matched against a scoreboard.
// Stats expectations follow PCIE_TAG_TRACKER_STATS_EN.
module tb_pcie_rd_tag_tracker;
   import ofs_fim_pcie_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pcie_rd_tag_tracker_if trk_if();

   logic [CPL_CREDIT_WIDTH:0]  credit_avail;
   logic [PCIE_EP_TAG_WIDTH:0] outstanding_cnt;
   logic                       err_unexp_cpl;
   logic                       err_cpl_timeout;
   t_tlp_tag                   timeout_tag;
   logic [15:0]                stat_timeout_cnt;
   logic [15:0]                stat_unexp_cnt;

   pcie_rd_tag_tracker #(
      .NUM_TAGS       (256),
      .TIMEOUT_CYCLES (256),
      .CREDIT_DW      (10000)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .trk              (trk_if),
      .credit_avail     (credit_avail),
      .outstanding_cnt  (outstanding_cnt),
      .err_unexp_cpl    (err_unexp_cpl),
      .err_cpl_timeout  (err_cpl_timeout),
      .timeout_tag      (timeout_tag),
      .stat_timeout_cnt (stat_timeout_cnt),
      .stat_unexp_cnt   (stat_unexp_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int unexp_q[$];
   int to_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, obs, exp, cyc);
      end
   endtask

   // Error-pulse scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (err_unexp_cpl) begin
            if (unexp_q.size() == 0) chk("unexp_spurious", int'(err_unexp_cpl), 0);
            else                     chk("unexp_cycle", cyc, unexp_q.pop_front());
         end
         if (err_cpl_timeout) begin
            if (to_q.size() == 0) chk("timeout_spurious", int'(err_cpl_timeout), 0);
            else                  chk("timeout_tag", int'(timeout_tag), to_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      int n;
      trk_if.alloc_req    = 1'b0;
      trk_if.alloc_len_dw = PCIE_MAX_LEN_WIDTH'(1);
      trk_if.cpl_valid    = 1'b0;
      trk_if.cpl_tag      = '0;
      trk_if.cpl_len_dw   = '0;
      trk_if.cpl_last     = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      unexp_q.delete();
      to_q.delete();
      chk("rst_credit", int'(credit_avail), 10000);
      chk("rst_outstanding", int'(outstanding_cnt), 0);
      chk("rst_ready", int'(trk_if.alloc_ready), 0);
      chk("rst_timeout_tag", int'(timeout_tag), 0);
      chk("rst_stat_unexp", int'(stat_unexp_cnt), 0);
      rst_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (trk_if.alloc_ready !== 1'b1 && n < 400) begin
         n++;
         @(negedge clk);
      end
      chk("init_cycles", n, 255);
      chk("init_tag", int'(trk_if.alloc_tag), 0);
      chk("init_credit", int'(credit_avail), 10000);
   endtask

   task automatic alloc(input int len, input int exp_tag);
      trk_if.alloc_len_dw = PCIE_MAX_LEN_WIDTH'(len);
      trk_if.alloc_req    = 1'b1;
      #1;
      chk("alloc_ready", int'(trk_if.alloc_ready), 1);
      chk("alloc_tag", int'(trk_if.alloc_tag), exp_tag);
      @(negedge clk);
      trk_if.alloc_req = 1'b0;
   endtask

   task automatic cpl(input int tag, input int len, input bit last, input bit unexp);
      trk_if.cpl_valid  = 1'b1;
      trk_if.cpl_tag    = t_tlp_tag'(tag);
      trk_if.cpl_len_dw = PCIE_MAX_LEN_WIDTH'(len);
      trk_if.cpl_last   = last;
      if (unexp) unexp_q.push_back(cyc + 1);
      @(negedge clk);
      trk_if.cpl_valid = 1'b0;
      trk_if.cpl_last  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      do_reset();

      // Split completion on tag 5 returns the full reservation
      for (int i = 0; i < 5; i++) alloc(1, i);
      alloc(16, 5);
      chk("s2_credit_alloc", int'(credit_avail), 9979);
      chk("s2_out_alloc", int'(outstanding_cnt), 6);
      cpl(5, 8, 1'b0, 1'b0);
      chk("s2_credit_part", int'(credit_avail), 9987);
      cpl(5, 8, 1'b1, 1'b0);
      chk("s2_credit_last", int'(credit_avail), 9995);
      chk("s2_out_last", int'(outstanding_cnt), 5);
      for (int i = 0; i < 5; i++) cpl(i, 1, 1'b1, 1'b0);
      chk("s2_credit_done", int'(credit_avail), 10000);
      chk("s2_out_done", int'(outstanding_cnt), 0);

      // Unexpected completions leave state untouched
      cpl(7, 4, 1'b1, 1'b1);
      cpl(7, 4, 1'b0, 1'b1);
      cpl(200, 1, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      chk("unexp_credit", int'(credit_avail), 10000);
      chk("unexp_out", int'(outstanding_cnt), 0);
      chk("unexp_pending", unexp_q.size(), 0);
`ifdef PCIE_TAG_TRACKER_STATS_EN
      chk("stat_unexp", int'(stat_unexp_cnt), 3);
`else
      chk("stat_unexp", int'(stat_unexp_cnt), 0);
`endif

      // Oversized partial completion returns only the remaining reservation
      alloc(4, 6);
      chk("over_credit_alloc", int'(credit_avail), 9996);
      cpl(6, 10, 1'b0, 1'b0);
      chk("over_credit_part", int'(credit_avail), 10000);
      cpl(6, 0, 1'b1, 1'b0);
      chk("over_credit_last", int'(credit_avail), 10000);
      chk("over_out", int'(outstanding_cnt), 0);

      // Timeout on tag 3 with no completion
      do_reset();
      for (int i = 0; i < 3; i++) alloc(1, i);
      for (int i = 0; i < 3; i++) cpl(i, 1, 1'b1, 1'b0);
      to_q.push_back(3);
      alloc(32, 3);
      chk("to_credit_alloc", int'(credit_avail), 9968);
      n = 0;
      while (to_q.size() != 0 && n < 512) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("to_pending", to_q.size(), 0);
      @(negedge clk);
      chk("to_credit", int'(credit_avail), 10000);
      chk("to_out", int'(outstanding_cnt), 0);
      chk("to_tag_held", int'(timeout_tag), 3);
`ifdef PCIE_TAG_TRACKER_STATS_EN
      chk("stat_timeout", int'(stat_timeout_cnt), 1);
`else
      chk("stat_timeout", int'(stat_timeout_cnt), 0);
`endif

      // Exhaust the pool, then free tag 9
      do_reset();
      repeat (8) @(negedge clk);
      for (int i = 0; i < 256; i++) alloc(1, i);
      chk("full_ready", int'(trk_if.alloc_ready), 0);
      chk("full_out", int'(outstanding_cnt), 256);
      chk("full_credit", int'(credit_avail), 9744);
      trk_if.cpl_valid  = 1'b1;
      trk_if.cpl_tag    = t_tlp_tag'(9);
      trk_if.cpl_len_dw = PCIE_MAX_LEN_WIDTH'(1);
      trk_if.cpl_last   = 1'b1;
      #1;
      chk("free_same_cycle", int'(trk_if.alloc_ready), 0);
      @(negedge clk);
      trk_if.cpl_valid = 1'b0;
      trk_if.cpl_last  = 1'b0;
      #1;
      chk("free_ready", int'(trk_if.alloc_ready), 1);
      chk("free_tag", int'(trk_if.alloc_tag), 9);
      chk("free_out", int'(outstanding_cnt), 255);
      chk("free_credit", int'(credit_avail), 9745);

      // Credit boundary and simultaneous alloc + completion
      do_reset();
      for (int i = 0; i < 9; i++) alloc(1000, i);
      chk("cr_credit", int'(credit_avail), 1000);
      trk_if.alloc_len_dw = PCIE_MAX_LEN_WIDTH'(1024);
      #1;
      chk("cr_short", int'(trk_if.alloc_ready), 0);
      trk_if.alloc_len_dw = PCIE_MAX_LEN_WIDTH'(1000);
      #1;
      chk("cr_exact", int'(trk_if.alloc_ready), 1);
      @(negedge clk);
      trk_if.alloc_req    = 1'b1;
      trk_if.alloc_len_dw = PCIE_MAX_LEN_WIDTH'(200);
      trk_if.cpl_valid    = 1'b1;
      trk_if.cpl_tag      = t_tlp_tag'(0);
      trk_if.cpl_len_dw   = PCIE_MAX_LEN_WIDTH'(500);
      trk_if.cpl_last     = 1'b0;
      #1;
      chk("net_ready", int'(trk_if.alloc_ready), 1);
      chk("net_tag", int'(trk_if.alloc_tag), 9);
      @(negedge clk);
      trk_if.alloc_req = 1'b0;
      trk_if.cpl_valid = 1'b0;
      chk("net_credit", int'(credit_avail), 1300);
      chk("net_out", int'(outstanding_cnt), 10);

      // Reset with tags in flight
      do_reset();
      chk("end_unexp_pending", unexp_q.size(), 0);
      chk("end_to_pending", to_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
